match_filter_pn: RTL and testbench

- Parametrised successor to the single-configuration RX correlator.
- Correlates the complex RX stream (r_input/i_input, qualified by rxstrobe) against a programmable NTAPS-long ±1 complex sequence using one time-multiplexed accumulator, then compares |re|+|im| against a programmable threshold.
- Adds double-buffered coefficient banks, a threshold register, match holdoff, priming and overrun detection.
- Sits between the RX decimator output and the inband packet logic; it is configured over the cwrite/caddr/cdata register path.

---
 rtl/match_filter_pn_if.sv | 31 +++
 rtl/match_filter_pn.sv | 160 ++++++++++++++++
 tb/tb_match_filter_pn.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/match_filter_pn_if.sv
// Sample, register-write and result signals of the PN correlator.
// master drives samples and register writes; slave is the correlator side.
interface match_filter_pn_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned NTAPS = 64
);
  localparam int unsigned ACC_W = IN_W + $clog2(NTAPS) + 1;

  logic signed [IN_W-1:0] r_input;
  logic signed [IN_W-1:0] i_input;
  logic                   rxstrobe;
  logic                   cwrite;
  logic [7:0]             caddr;
  logic [31:0]            cdata;
  logic                   valid;
  logic                   match;
  logic                   busy;
  logic                   overrun;
  logic [ACC_W:0]         corr_mag;
  logic [15:0]            debugbus;

  modport master (
    output r_input, i_input, rxstrobe, cwrite, caddr, cdata,
    input  valid, match, busy, overrun, corr_mag, debugbus
  );

  modport slave (
    input  r_input, i_input, rxstrobe, cwrite, caddr, cdata,
    output valid, match, busy, overrun, corr_mag, debugbus
  );
endinterface

// File: rtl/match_filter_pn.sv
// Programmable +/-1 complex PN correlator: one time-multiplexed accumulator,
// double-buffered code banks, threshold match with holdoff, priming and overrun.
module match_filter_pn #(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned NTAPS   = 64,
  parameter int unsigned HOLDOFF = 32
) (
  input logic              clk,
  input logic              reset,
  match_filter_pn_if.slave bus
);
  localparam int unsigned ACC_W  = IN_W + $clog2(NTAPS) + 1;
  localparam int unsigned NWORDS = NTAPS / 16;
  localparam int unsigned TI_W   = $clog2(NTAPS);
  localparam int unsigned CNT_W  = $clog2(NTAPS + 1);
  localparam int unsigned HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                  state;
  logic signed [IN_W-1:0]  dl_r [NTAPS];
  logic signed [IN_W-1:0]  dl_i [NTAPS];
  logic [2*NTAPS-1:0]      shadow;
  logic [2*NTAPS-1:0]      active;
  logic [ACC_W:0]          threshold;
  logic                    enable;
  logic                    pending;
  logic [CNT_W-1:0]        prime;
  logic [CNT_W-1:0]        tap;
  logic [HOLD_W-1:0]       holdoff;
  logic signed [ACC_W-1:0] acc_re, acc_im, term_re, term_im;
  logic                    valid_q, match_q, busy_q, overrun_q;
  logic [ACC_W:0]          corr_q;
  logic [15:0]             debug_q;

  logic                    ctrl_wr_c, thr_wr_c;
  logic [TI_W-1:0]         tap_idx_c;
  logic signed [ACC_W-1:0] xr_c, xi_c, term_re_c, term_im_c;
  logic                    ci_c, cq_c;
  logic signed [ACC_W:0]   re_x_c, im_x_c;
  logic [ACC_W:0]          abs_re_c, abs_im_c, mag_c;
  logic                    hit_c;

  assign ctrl_wr_c = bus.cwrite && (bus.caddr == 8'hFF);
  assign thr_wr_c  = bus.cwrite && (bus.caddr == 8'hFE);
  assign tap_idx_c = tap[TI_W-1:0];

  // Signed tap term (x * conj(c)) and final |re|+|im| magnitude
  always_comb begin
    xr_c      = ACC_W'(dl_r[tap_idx_c]);
    xi_c      = ACC_W'(dl_i[tap_idx_c]);
    ci_c      = active[{tap_idx_c, 1'b0}];
    cq_c      = active[{tap_idx_c, 1'b1}];
    term_re_c = (ci_c ? -xr_c : xr_c) + (cq_c ? -xi_c : xi_c);
    term_im_c = (ci_c ? -xi_c : xi_c) - (cq_c ? -xr_c : xr_c);
    re_x_c    = (ACC_W + 1)'(acc_re);
    im_x_c    = (ACC_W + 1)'(acc_im);
    abs_re_c  = re_x_c[ACC_W] ? $unsigned(-re_x_c) : $unsigned(re_x_c);
    abs_im_c  = im_x_c[ACC_W] ? $unsigned(-im_x_c) : $unsigned(im_x_c);
    mag_c     = abs_re_c + abs_im_c;
    hit_c     = enable && (prime == CNT_W'(NTAPS)) && (holdoff == '0) &&
                (mag_c >= threshold);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shadow    <= '0;
      active    <= '0;
      threshold <= '0;
      enable    <= 1'b0;
      pending   <= 1'b0;
      prime     <= '0;
      tap       <= '0;
      holdoff   <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      term_re   <= '0;
      term_im   <= '0;
      valid_q   <= 1'b0;
      match_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      corr_q    <= '0;
      debug_q   <= '0;
      for (int unsigned k = 0; k < NTAPS; k++) begin
        dl_r[k] <= '0;
        dl_i[k] <= '0;
      end
    end else begin
      valid_q <= 1'b0;
      match_q <= 1'b0;

      for (int unsigned k = 0; k < NWORDS; k++) begin
        if (bus.cwrite && (bus.caddr == 8'(k))) shadow[32*k +: 32] <= bus.cdata;
      end
      if (thr_wr_c) threshold <= bus.cdata[ACC_W:0];
      if (ctrl_wr_c) enable <= bus.cdata[1];

      // A drop in the same cycle as a clear wins
      overrun_q <= (overrun_q && !(ctrl_wr_c && bus.cdata[2])) ||
                   (bus.rxstrobe && (state != IDLE));

      if (ctrl_wr_c && bus.cdata[0]) pending <= 1'b1;
      else if (state == IDLE)        pending <= 1'b0;

      case (state)
        IDLE: begin
          if (pending) active <= shadow;
          if (bus.rxstrobe) begin
            dl_r[0] <= bus.r_input;
            dl_i[0] <= bus.i_input;
            for (int unsigned k = 1; k < NTAPS; k++) begin
              dl_r[k] <= dl_r[k-1];
              dl_i[k] <= dl_i[k-1];
            end
            if (pending)                         prime <= CNT_W'(1);
            else if (prime != CNT_W'(NTAPS))     prime <= prime + CNT_W'(1);
            acc_re <= '0;
            acc_im <= '0;
            tap    <= '0;
            busy_q <= 1'b1;
            state  <= ACCUM;
          end else if (pending) begin
            prime <= '0;
          end
        end
        // Term for tap n is registered one cycle before it is accumulated
        ACCUM: begin
          term_re <= term_re_c;
          term_im <= term_im_c;
          if (tap != '0) begin
            acc_re <= acc_re + term_re;
            acc_im <= acc_im + term_im;
          end
          tap <= tap + CNT_W'(1);
          if (tap == CNT_W'(NTAPS)) state <= DONE;
        end
        DONE: begin
          corr_q  <= mag_c;
          debug_q <= mag_c[ACC_W -: 16];
          valid_q <= 1'b1;
          match_q <= hit_c;
          busy_q  <= 1'b0;
          if (hit_c)                holdoff <= HOLD_W'(HOLDOFF);
          else if (holdoff != '0)   holdoff <= holdoff - HOLD_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.valid    = valid_q;
  assign bus.match    = match_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;
  assign bus.corr_mag = corr_q;
  assign bus.debugbus = debug_q;
endmodule

// File: tb/tb_match_filter_pn.sv
// Bench for match_filter_pn: complex-correlation reference model checked every
// cycle, plus literal expectations for priming, holdoff, code alignment and overrun.
module tb_match_filter_pn;
  localparam int unsigned IN_W    = 16;
  localparam int unsigned NTAPS   = 16;
  localparam int unsigned HOLDOFF = 4;
  localparam int unsigned ACC_W   = IN_W + $clog2(NTAPS) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  match_filter_pn_if #(.IN_W(IN_W), .NTAPS(NTAPS)) bus ();

  match_filter_pn #(.IN_W(IN_W), .NTAPS(NTAPS), .HOLDOFF(HOLDOFF)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: delay line as sample arrays, correlation as sum of x*conj(c)
  int        m_r [NTAPS];
  int        m_i [NTAPS];
  bit        m_ci[NTAPS];
  bit        m_cq[NTAPS];
  bit [31:0] m_shadow_w[NTAPS/16];
  bit [31:0] m_w;
  longint    m_thr = 0, m_next = 0, e_mag = 0;
  bit        m_en = 0, m_pend = 0, m_ovr = 0, m_fly = 0;
  bit        m_idle, m_drop, m_clr;
  int        m_prime = 0, m_hold = 0, m_t = 0;
  bit        e_valid = 0, e_match = 0, e_busy = 0;

  function automatic longint model_corr();
    longint re = 0, im = 0;
    int cr, cq;
    for (int j = 0; j < NTAPS; j++) begin
      cr = m_ci[j] ? -1 : 1;
      cq = m_cq[j] ? -1 : 1;
      re += longint'(m_r[j] * cr + m_i[j] * cq);
      im += longint'(m_i[j] * cr - m_r[j] * cq);
    end
    return (re < 0 ? -re : re) + (im < 0 ? -im : im);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < NTAPS; j++) begin
        m_r[j] = 0; m_i[j] = 0; m_ci[j] = 0; m_cq[j] = 0;
      end
      for (int k = 0; k < NTAPS/16; k++) m_shadow_w[k] = '0;
      m_thr = 0; m_next = 0; e_mag = 0;
      m_en = 0; m_pend = 0; m_ovr = 0; m_fly = 0;
      m_prime = 0; m_hold = 0; m_t = 0;
      e_valid = 0; e_match = 0; e_busy = 0;
    end else begin
      m_idle = 1; m_drop = 0; m_clr = 0;
      e_valid = 0; e_match = 0;
      if (m_fly) begin
        m_t++;
        m_idle = 0;
        if (m_t == NTAPS + 2) begin
          e_valid = 1;
          e_mag   = m_next;
          e_match = m_en && (m_prime == NTAPS) && (m_hold == 0) && (m_next >= m_thr);
          if (e_match)         m_hold = HOLDOFF;
          else if (m_hold > 0) m_hold--;
          m_fly = 0;
        end
      end
      if (m_idle && m_pend) begin
        for (int j = 0; j < NTAPS; j++) begin
          m_w = m_shadow_w[j/16] >> (2 * (j % 16));
          m_ci[j] = m_w[0];
          m_cq[j] = m_w[1];
        end
        m_prime = 0;
        m_pend  = 0;
      end
      if (bus.rxstrobe) begin
        if (m_idle) begin
          for (int j = NTAPS - 1; j > 0; j--) begin
            m_r[j] = m_r[j-1];
            m_i[j] = m_i[j-1];
          end
          m_r[0] = int'(bus.r_input);
          m_i[0] = int'(bus.i_input);
          if (m_prime < NTAPS) m_prime++;
          m_next = model_corr();
          m_fly  = 1;
          m_t    = 0;
        end else begin
          m_drop = 1;
        end
      end
      if (bus.cwrite) begin
        if (int'(bus.caddr) < NTAPS/16) m_shadow_w[bus.caddr] = bus.cdata;
        else if (bus.caddr == 8'hFE) m_thr = longint'(bus.cdata[ACC_W:0]);
        else if (bus.caddr == 8'hFF) begin
          if (bus.cdata[0]) m_pend = 1;
          m_en  = bus.cdata[1];
          m_clr = bus.cdata[2];
        end
      end
      m_ovr  = (m_ovr && !m_clr) || m_drop;
      e_busy = m_fly;
    end
  end

  // Every output is meaningful every cycle
  always @(negedge clk) begin
    if (chk_on) begin
      check("valid",    longint'(bus.valid),    longint'(e_valid));
      check("match",    longint'(bus.match),    longint'(e_match));
      check("busy",     longint'(bus.busy),     longint'(e_busy));
      check("overrun",  longint'(bus.overrun),  longint'(m_ovr));
      check("corr_mag", longint'(bus.corr_mag), e_mag);
      check("debugbus", longint'(bus.debugbus), (e_mag >> (ACC_W - 15)) & 64'hFFFF);
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cwrite = 1'b1; bus.caddr = a; bus.cdata = d;
    @(negedge clk);
    bus.cwrite = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output longint mag, output bit m);
    bit seen = 0;
    lat = 0; mag = 0; m = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.valid) begin
        seen = 1;
        mag  = longint'(bus.corr_mag);
        m    = bus.match;
      end
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL valid_timeout: no valid within %0d clocks", lat);
    end
  endtask

  task automatic pulse(input int r, input int i);
    @(negedge clk);
    bus.r_input = IN_W'(r); bus.i_input = IN_W'(i); bus.rxstrobe = 1'b1;
    @(negedge clk);
    bus.rxstrobe = 1'b0;
  endtask

  task automatic send(input int r, input int i, output int lat, output longint mag, output bit m);
    pulse(r, i);
    wait_valid(lat, mag, m);
  endtask

  function automatic int chip(input bit [31:0] c, input int bitpos);
    bit [31:0] w = c >> bitpos;
    return w[0] ? -1000 : 1000;
  endfunction

  initial begin
    int lat, nv;
    longint mag;
    bit m;
    bit [31:0] code = 32'h9C3A_5E71;

    bus.r_input = '0; bus.i_input = '0; bus.rxstrobe = 1'b0;
    bus.cwrite = 1'b0; bus.caddr = '0; bus.cdata = '0;
    #1 rst_n = 1'b0;
    #1 chk_on = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset
    repeat (100) @(negedge clk);
    check("idle_busy", longint'(bus.busy), 0);
    check("idle_mag", longint'(bus.corr_mag), 0);

    // Priming and threshold with all-+1 code
    wr(8'hFE, 32'd3000);
    wr(8'hFF, 32'h3);
    for (int k = 1; k <= 16; k++) begin
      send(100, 0, lat, mag, m);
      if (k == 1)  check("latency_first", lat, NTAPS + 2);
      if (k < 16)  check("prime_nomatch", longint'(m), 0);
      if (k == 15) check("prime15_mag", mag, 3000);
      if (k == 16) begin
        check("prime16_mag", mag, 3200);
        check("prime16_match", longint'(m), 1);
      end
    end

    // Holdoff
    for (int k = 1; k <= 5; k++) begin
      send(100, 0, lat, mag, m);
      check("holdoff_mag", mag, 3200);
      check("holdoff_match", longint'(m), (k == 5) ? 1 : 0);
    end

    // Code alignment
    wr(8'h00, code);
    wr(8'hFF, 32'h3);
    for (int j = NTAPS - 1; j >= 0; j--) send(chip(code, 2*j), chip(code, 2*j + 1), lat, mag, m);
    check("aligned_mag", mag, 32000);
    check("aligned_latency", lat, 18);
    send(chip(code, 2*(NTAPS-1)), chip(code, 2*(NTAPS-1) + 1), lat, mag, m);
    n_cmp++;
    if (!(mag < 32000)) begin
      n_bad++;
      $display("FAIL misaligned_mag: got %0d required below 32000", mag);
    end

    // Overrun: second strobe 5 clocks later is dropped
    pulse(500, -300);
    repeat (4) @(negedge clk);
    bus.r_input = IN_W'(7000); bus.i_input = IN_W'(7000); bus.rxstrobe = 1'b1;
    @(negedge clk);
    bus.rxstrobe = 1'b0;
    wait_valid(lat, mag, m);
    @(negedge clk);
    check("overrun_set", longint'(bus.overrun), 1);
    pulse(-250, 900);
    repeat (3) @(negedge clk);
    bus.rxstrobe = 1'b1; bus.cwrite = 1'b1; bus.caddr = 8'hFF; bus.cdata = 32'h6;
    @(negedge clk);
    bus.rxstrobe = 1'b0; bus.cwrite = 1'b0;
    check("overrun_drop_wins", longint'(bus.overrun), 1);
    wait_valid(lat, mag, m);
    wr(8'hFF, 32'h4);
    @(negedge clk);
    check("overrun_cleared", longint'(bus.overrun), 0);
    wr(8'hFF, 32'h2);

    // Bank commit during accumulation takes effect on the next correlation
    pulse(300, -200);
    wr(8'h00, ~code);
    wr(8'hFF, 32'h3);
    wait_valid(lat, mag, m);
    send(300, -200, lat, mag, m);
    send(-1200, 450, lat, mag, m);

    // Reset mid-accumulation
    pulse(800, 800);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_mag", longint'(bus.corr_mag), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.valid) nv++;
    end
    check("rst_no_valid", nv, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
